shim_sts_sync_latch: RTL and testbench

//  Parametrised status-capture stage from the SPI clock domain into the AXI (aclk) domain.
//  For each of N_BITS flags it provides:
//   - a multi-stage synchroniser;
//   - a per-bit glitch filter;
//   - sticky latching, with a masked clear handshake;
//   - a first-fault record carrying a free-running timestamp, plus an interrupt output.
//  It sits between the SPI status sources and the AXI status registers.

---
 rtl/shim_sts_sync_latch.sv | 143 ++++++++++++++
 tb/tb_shim_sts_sync_latch.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shim_sts_sync_latch.sv
// Status capture from the SPI domain into aclk: synchroniser, glitch filter,
// sticky latch with a masked clear handshake, first-fault record and interrupt.
module shim_sts_sync_latch #(
  parameter int                N_BITS        = 32,
  parameter int                SYNC_STAGES   = 2,
  parameter int                FILTER_CYCLES = 1,
  parameter int                TS_WIDTH      = 32,
  parameter logic [N_BITS-1:0] IRQ_MASK      = {N_BITS{1'b1}},
  localparam int               IDX_W         = (N_BITS > 1) ? $clog2(N_BITS) : 1
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [N_BITS-1:0]   sts_in,
  input  logic                clr_req,
  input  logic [N_BITS-1:0]   clr_mask,
  output logic                clr_ack,
  output logic [N_BITS-1:0]   sts_live,
  output logic [N_BITS-1:0]   sts_sticky,
  output logic                first_fault_valid,
  output logic [IDX_W-1:0]    first_fault_idx,
  output logic [TS_WIDTH-1:0] first_fault_time,
  output logic                irq
);

  localparam int               CNT_W    = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  // Clear handshake: clr_req is a level, clr_ack a single-cycle pulse per
  // accepted request; a new request is only accepted once clr_req returned low.
  typedef enum logic [1:0] {
    CLR_IDLE     = 2'd0,
    CLR_ACK      = 2'd1,
    CLR_WAIT_LOW = 2'd2
  } clr_state_t;

  logic [N_BITS-1:0]   sync_q [SYNC_STAGES];
  logic [CNT_W-1:0]    cnt_q  [N_BITS];
  logic [N_BITS-1:0]   live_q;
  logic [N_BITS-1:0]   sticky_q;
  logic [N_BITS-1:0]   syn;
  logic [N_BITS-1:0]   clr_vec;
  logic [TS_WIDTH-1:0] ts_q;
  logic                ff_valid_q;
  logic [IDX_W-1:0]    ff_idx_q;
  logic [IDX_W-1:0]    ff_idx_d;
  logic [TS_WIDTH-1:0] ff_time_q;
  logic                irq_q;
  logic                clr_accept;
  clr_state_t          state_q;
  clr_state_t          state_d;

  assign syn = sync_q[SYNC_STAGES-1];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= sts_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // A bit moves only after FILTER_CYCLES consecutive synced samples disagree with it.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      live_q <= '0;
      for (int b = 0; b < N_BITS; b++) cnt_q[b] <= '0;
    end else begin
      for (int b = 0; b < N_BITS; b++) begin
        if (syn[b] == live_q[b]) begin
          cnt_q[b] <= '0;
        end else if (cnt_q[b] == CNT_LAST) begin
          live_q[b] <= syn[b];
          cnt_q[b]  <= '0;
        end else begin
          cnt_q[b] <= cnt_q[b] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_accept = 1'b0;
    case (state_q)
      CLR_IDLE: begin
        if (clr_req) begin
          clr_accept = 1'b1;
          state_d    = CLR_ACK;
        end
      end
      CLR_ACK:      state_d = clr_req ? CLR_WAIT_LOW : CLR_IDLE;
      CLR_WAIT_LOW: if (!clr_req) state_d = CLR_IDLE;
      default:      state_d = CLR_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= CLR_IDLE;
    else          state_q <= state_d;
  end

  assign clr_vec = clr_accept ? clr_mask : '0;

  // Lowest set sticky index wins the first-fault record.
  always_comb begin
    ff_idx_d = '0;
    for (int i = N_BITS - 1; i >= 0; i--) begin
      if (sticky_q[i]) ff_idx_d = IDX_W'(i);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sticky_q   <= '0;
      ts_q       <= '0;
      ff_valid_q <= 1'b0;
      ff_idx_q   <= '0;
      ff_time_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      sticky_q <= (sticky_q & ~clr_vec) | live_q;
      ts_q     <= ts_q + 1'b1;
      irq_q    <= |(sticky_q & IRQ_MASK);
      if (ff_valid_q && clr_accept && clr_mask[ff_idx_q]) begin
        ff_valid_q <= 1'b0;
      end else if (!ff_valid_q && (|sticky_q)) begin
        ff_valid_q <= 1'b1;
        ff_idx_q   <= ff_idx_d;
        ff_time_q  <= ts_q;
      end
    end
  end

  assign clr_ack           = (state_q == CLR_ACK);
  assign sts_live          = live_q;
  assign sts_sticky        = sticky_q;
  assign first_fault_valid = ff_valid_q;
  assign first_fault_idx   = ff_idx_q;
  assign first_fault_time  = ff_time_q;
  assign irq               = irq_q;

endmodule

// File: tb/tb_shim_sts_sync_latch.sv
// Bench for shim_sts_sync_latch: a default instance and a narrow, slow-filter
// instance with a 4-bit timestamp, both checked against a behavioural model.
module tb_shim_sts_sync_latch;

  logic        clk;
  logic        aresetn;

  logic [31:0] a_in, a_mask;
  logic        a_req;
  logic        a_clr_ack, a_ffv, a_irq;
  logic [31:0] a_live, a_sticky, a_fft;
  logic [4:0]  a_ffi;

  logic [11:0] b_in, b_mask;
  logic        b_req;
  logic        b_clr_ack, b_ffv, b_irq;
  logic [11:0] b_live, b_sticky;
  logic [3:0]  b_fft;
  logic [3:0]  b_ffi;

  int n_cmp;
  int n_bad;

  shim_sts_sync_latch u_dut_a (
    .aclk(clk), .aresetn(aresetn), .sts_in(a_in), .clr_req(a_req), .clr_mask(a_mask),
    .clr_ack(a_clr_ack), .sts_live(a_live), .sts_sticky(a_sticky),
    .first_fault_valid(a_ffv), .first_fault_idx(a_ffi), .first_fault_time(a_fft), .irq(a_irq)
  );

  shim_sts_sync_latch #(
    .N_BITS(12), .SYNC_STAGES(2), .FILTER_CYCLES(4), .TS_WIDTH(4), .IRQ_MASK(12'h0F0)
  ) u_dut_b (
    .aclk(clk), .aresetn(aresetn), .sts_in(b_in), .clr_req(b_req), .clr_mask(b_mask),
    .clr_ack(b_clr_ack), .sts_live(b_live), .sts_sticky(b_sticky),
    .first_fault_valid(b_ffv), .first_fault_idx(b_ffi), .first_fault_time(b_fft), .irq(b_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: hist[0] is the newest raw sample taken at an edge.
  typedef struct packed {
    logic [7:0][31:0] hist;
    logic [31:0]      live;
    logic [31:0]      sticky;
    logic             ack;
    logic             hold;
    logic             ffv;
    logic [31:0]      ffi;
    logic [31:0]      fft;
    logic [31:0]      ts;
    logic             irq;
  } model_t;

  model_t ma, mb;

  function automatic model_t model_step(input model_t m, input logic [31:0] in_v,
                                        input logic req, input logic [31:0] mask,
                                        input int sync, input int filt, input int tsw,
                                        input logic [31:0] irq_mask);
    model_t      n;
    logic [31:0] all1, any1, clrv, tsm;
    logic        accept;
    n    = m;
    all1 = '1;
    any1 = '0;
    // A bit follows when the last filt synced samples all agree on a value.
    for (int k = sync - 1; k <= sync + filt - 2; k++) begin
      all1 &= m.hist[k];
      any1 |= m.hist[k];
    end
    n.live = (m.live & any1) | all1;
    for (int k = 7; k > 0; k--) n.hist[k] = m.hist[k-1];
    n.hist[0] = in_v;
    accept   = req && !m.ack && !m.hold;
    clrv     = accept ? mask : 32'h0;
    n.sticky = (m.sticky & ~clrv) | m.live;
    n.ack    = accept;
    n.hold   = (m.ack || m.hold) && req;
    tsm      = (tsw >= 32) ? 32'hFFFF_FFFF : ((32'h1 << tsw) - 32'h1);
    n.ts     = (m.ts + 32'h1) & tsm;
    n.irq    = |(m.sticky & irq_mask);
    if (m.ffv && accept && mask[m.ffi]) begin
      n.ffv = 1'b0;
    end else if (!m.ffv && m.sticky != 0) begin
      n.ffv = 1'b1;
      n.fft = m.ts;
      for (int k = 0; k < 32; k++) begin
        if (m.sticky[k]) begin
          n.ffi = k;
          break;
        end
      end
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("a_live",   a_live,           ma.live);
    check("a_sticky", a_sticky,         ma.sticky);
    check("a_ack",    32'(a_clr_ack),   32'(ma.ack));
    check("a_ffv",    32'(a_ffv),       32'(ma.ffv));
    check("a_ffi",    32'(a_ffi),       ma.ffi);
    check("a_fft",    a_fft,            ma.fft);
    check("a_irq",    32'(a_irq),       32'(ma.irq));
    check("b_live",   32'(b_live),      mb.live);
    check("b_sticky", 32'(b_sticky),    mb.sticky);
    check("b_ack",    32'(b_clr_ack),   32'(mb.ack));
    check("b_ffv",    32'(b_ffv),       32'(mb.ffv));
    check("b_ffi",    32'(b_ffi),       mb.ffi);
    check("b_fft",    32'(b_fft),       mb.fft);
    check("b_irq",    32'(b_irq),       32'(mb.irq));
  endtask

  // One active edge: advance the model with the inputs seen at the edge, then compare.
  task automatic tick();
    @(posedge clk);
    if (!aresetn) begin
      ma = '0;
      mb = '0;
    end else begin
      ma = model_step(ma, a_in, a_req, a_mask, 2, 1, 32, 32'hFFFF_FFFF);
      mb = model_step(mb, 32'(b_in), b_req, 32'(b_mask), 2, 4, 4, 32'h0000_00F0);
    end
    #1;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Asynchronous reset pulse placed between edges; outputs must drop immediately.
  task automatic pulse_reset();
    #2;
    aresetn = 1'b0;
    #1;
    check("rst_a_out", 32'(|{a_live, a_sticky, a_clr_ack, a_ffv, a_ffi, a_fft, a_irq}), 32'h0);
    check("rst_b_out", 32'(|{b_live, b_sticky, b_clr_ack, b_ffv, b_ffi, b_fft, b_irq}), 32'h0);
    ma = '0;
    mb = '0;
    tick();
    #2;
    aresetn = 1'b1;
  endtask

  int acks;
  int live_hits;

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    aresetn = 1'b0;
    a_in = '0; a_req = 1'b0; a_mask = '0;
    b_in = '0; b_req = 1'b0; b_mask = '0;
    ma = '0;
    mb = '0;
    ticks(2);
    #2;
    aresetn = 1'b1;

    // Single fault on bit 5 through the default instance.
    a_in = 32'h20;
    ticks(2);
    check("s1_live_e2", 32'(a_live[5]), 32'h0);
    tick();
    check("s1_live_e3", 32'(a_live[5]), 32'h1);
    tick();
    check("s1_sticky_e4", 32'(a_sticky[5]), 32'h1);
    check("s1_irq_e4", 32'(a_irq), 32'h0);
    tick();
    check("s1_ffv_e5", 32'(a_ffv), 32'h1);
    check("s1_ffi_e5", 32'(a_ffi), 32'h5);
    check("s1_irq_e5", 32'(a_irq), 32'h1);

    // Two simultaneous faults, masked clear of the recorded one, re-capture.
    pulse_reset();
    a_in = 32'h208;
    ticks(5);
    check("s3_ffi_first", 32'(a_ffi), 32'h3);
    a_in = '0;
    ticks(3);
    a_req = 1'b1; a_mask = 32'h8;
    tick();
    a_req = 1'b0;
    check("s3_ack", 32'(a_clr_ack), 32'h1);
    check("s3_sticky", a_sticky, 32'h200);
    check("s3_ffv_cleared", 32'(a_ffv), 32'h0);
    tick();
    check("s3_ack_gone", 32'(a_clr_ack), 32'h0);
    check("s3_ffv_recap", 32'(a_ffv), 32'h1);
    check("s3_ffi_recap", 32'(a_ffi), 32'h9);

    // Clear while the bit is still live; long request gives exactly one ack.
    a_in = 32'h80;
    ticks(4);
    a_req = 1'b1; a_mask = 32'h80;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      acks += int'(a_clr_ack);
    end
    a_req = 1'b0;
    ticks(2);
    check("s4_ack_count", 32'(acks), 32'h1);
    check("s4_set_wins", 32'(a_sticky[7]), 32'h1);

    // Glitch filter on the slow instance: 3-cycle pulse rejected, then 6-edge latency.
    pulse_reset();
    b_in = 12'h001;
    ticks(3);
    b_in = 12'h000;
    live_hits = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      live_hits += int'(b_live[0]);
    end
    check("s2_glitch", 32'(live_hits), 32'h0);
    b_in = 12'h001;
    ticks(5);
    check("s2_live_e5", 32'(b_live[0]), 32'h0);
    tick();
    check("s2_live_e6", 32'(b_live[0]), 32'h1);

    // Capture exactly at timestamp 15 of a 4-bit counter.
    pulse_reset();
    b_in = 12'h000;
    ticks(8);
    b_in = 12'h002;
    ticks(8);
    check("s5_ffv", 32'(b_ffv), 32'h1);
    check("s5_fft", 32'(b_fft), 32'hF);
    check("s5_ffi", 32'(b_ffi), 32'h1);

    // Reset mid-filter (B) and mid-ACK (A); request held across the reset.
    b_in = 12'h000;
    ticks(2);
    a_req = 1'b1; a_mask = 32'h0;
    tick();
    check("s6_in_ack", 32'(a_clr_ack), 32'h1);
    pulse_reset();
    tick();
    check("s6_idle_accept", 32'(a_clr_ack), 32'h1);
    a_req = 1'b0;
    ticks(2);

    // Randomised traffic on both instances.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) a_in ^= (32'h1 << $urandom_range(0, 31));
      if ($urandom_range(0, 15) == 0) a_in = '0;
      if ($urandom_range(0, 2) == 0) b_in ^= 12'(12'h1 << $urandom_range(0, 11));
      if ($urandom_range(0, 15) == 0) b_in = '0;
      if (!a_req) a_req = ($urandom_range(0, 9) == 0);
      else        a_req = ($urandom_range(0, 3) != 0);
      if (!b_req) b_req = ($urandom_range(0, 9) == 0);
      else        b_req = ($urandom_range(0, 3) != 0);
      a_mask = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      b_mask = 12'($urandom);
      if (i == 700) pulse_reset();
      else          tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
